// File: rtl/nibble_serial_adder32.sv
//==============================================================================
// Module      : nibble_serial_adder32 (with helper slice fulladder4)
// Description : Sequential 4N-bit adder. A single 4-bit ripple slice is reused
//               once per nibble, LSB first, with the slice carry-out fed back
//               through a register. Operands arrive and results leave over
//               valid/ready handshakes.
//               Optional macro FULLADDER32_SUB_EN adds a Sub input that turns
//               the operation into A-B (B inverted, carry-in forced to 1).
//               N must be at least 2.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

// 4-bit ripple-carry slice; the only adder hardware in the serial datapath.
module fulladder4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Pin,
    output logic [3:0] S,
    output logic       Pout
);
    logic [4:0] w_c;

    assign w_c[0] = Pin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign S[i]       = A[i] ^ B[i] ^ w_c[i];
        assign w_c[i + 1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
    end

    assign Pout = w_c[4];
endmodule

module nibble_serial_adder32 #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*N-1:0] A,
    input  logic [4*N-1:0] B,
    input  logic           Pin,
`ifdef FULLADDER32_SUB_EN
    input  logic           Sub,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*N-1:0] S,
    output logic           Pout,
    output logic           busy
);
    localparam int c_width = 4 * N;
    localparam int c_cnt_w = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_width-1:0] r_a;
    logic [c_width-1:0] r_b;
    // Holds the sum nibbles produced so far; the newest nibble enters at the top
    // so after N-1 nibbles it is exactly the low 4(N-1) bits of the result.
    logic [c_width-5:0] r_acc;
    logic [c_width-5:0] w_acc_shift;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_width-1:0] r_s;
    logic               r_pout;

    logic               w_accept;
    logic               w_run;
    logic               w_last;
    logic [3:0]         w_sum;
    logic               w_cout;
    logic [c_width-1:0] w_b_load;
    logic               w_c_load;

`ifdef FULLADDER32_SUB_EN
    // Two's-complement subtract: A + ~B + 1; Pin is ignored while subtracting.
    assign w_b_load = Sub ? ~B : B;
    assign w_c_load = Sub ? 1'b1 : Pin;
`else
    assign w_b_load = B;
    assign w_c_load = Pin;
`endif

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign busy      = (r_state != c_st_idle);
    assign S         = r_s;
    assign Pout      = r_pout;

    assign w_accept = in_valid && (r_state == c_st_idle);
    assign w_run    = (r_state == c_st_run);
    assign w_last   = w_run && (r_cnt == c_last);

    fulladder4 u_slice (
        .A    (r_a[3:0]),
        .B    (r_b[3:0]),
        .Pin  (r_carry),
        .S    (w_sum),
        .Pout (w_cout)
    );

    if (N > 2) begin : g_acc_wide
        assign w_acc_shift = {w_sum, r_acc[c_width-5:4]};
    end else begin : g_acc_narrow
        assign w_acc_shift = w_sum;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept, N nibble cycles, then hold until consumed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept)  w_state_nxt = c_st_run;
            c_st_run:  if (w_last)    w_state_nxt = c_st_done;
            c_st_done: if (out_ready) w_state_nxt = c_st_idle;
            default:                  w_state_nxt = c_st_idle;
        endcase
    end

    // Operand capture, nibble-serial add, and result load on the final nibble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_pout  <= 1'b0;
        end else if (w_accept) begin
            r_a     <= A;
            r_b     <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a     <= {4'b0000, r_a[c_width-1:4]};
            r_b     <= {4'b0000, r_b[c_width-1:4]};
            r_acc   <= w_acc_shift;
            r_carry <= w_cout;
            if (w_last) begin
                r_s    <= {w_sum, r_acc};
                r_pout <= w_cout;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder32.sv
//==============================================================================
// Module      : tb_nibble_serial_adder32
// Description : Self-checking bench for nibble_serial_adder32 (N=8). An
//               arithmetic reference model predicts handshake flags and the
//               result every cycle; directed vectors add literal expectations.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_nibble_serial_adder32;
    localparam int NN = 8;
    localparam int W  = 4 * NN;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Pin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] S;
    logic         Pout;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    nibble_serial_adder32 #(.N(NN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Pin       (Pin),
`ifdef FULLADDER32_SUB_EN
        .Sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Pout      (Pout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: whole-word arithmetic, a cycle countdown and a phase.
    int           m_phase;   // 0 idle, 1 computing, 2 result held
    int           m_left;
    logic [W:0]   m_exp;
    logic [W-1:0] m_s;
    logic         m_pout;

    function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic p, input logic sb);
        if (sb) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b} + (W+1)'(p);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_left  <= 0;
            m_exp   <= '0;
            m_s     <= '0;
            m_pout  <= 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_exp   <= model_sum(A, B, Pin, sub);
                    m_left  <= NN;
                    m_phase <= 1;
                end
                1: if (m_left == 1) begin
                    m_s     <= m_exp[W-1:0];
                    m_pout  <= m_exp[W];
                    m_phase <= 2;
                end else begin
                    m_left <= m_left - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic p, input logic sb);
        @(posedge clk); #1;
        A = a; B = b; Pin = p; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; Pin = ~p;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic p, input logic sb,
                          input logic [W-1:0] exp_s, input logic exp_p);
        int lat;
        start_op(a, b, p, sb);
        wait_valid(lat);
        chk({name, "_latency"}, 32'(lat), 32'(NN));
        chk({name, "_S"}, S, exp_s);
        chk({name, "_Pout"}, 32'(Pout), 32'(exp_p));
        release_out();
    endtask

    logic [W-1:0] tp_a [4] = '{32'h0000_0001, 32'h8000_0000, 32'h0F0F_0F0F, 32'h0000_0064};
    logic [W-1:0] tp_b [4] = '{32'h0000_0001, 32'h8000_0000, 32'hF0F0_F0F0, 32'h0000_00C8};
    logic         tp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] tp_s [4] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 32'h0000_012C};
    logic         tp_p [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        fork
            // Per-cycle comparison against the reference model.
            forever begin
                @(negedge clk);
                chk("cyc_in_ready",  32'(in_ready),  32'(m_phase == 0));
                chk("cyc_out_valid", 32'(out_valid), 32'(m_phase == 2));
                chk("cyc_busy",      32'(busy),      32'(m_phase != 0));
                chk("cyc_S",         S,              m_s);
                chk("cyc_Pout",      32'(Pout),      32'(m_pout));
            end
            begin
                int lat;
                int acc_cyc [4];
                int n_acc;
                int n_res;
                int cyc;

                #1 rst = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("reset_S",         S,               32'h0);
                chk("reset_Pout",      32'(Pout),       32'h0);
                chk("reset_out_valid", 32'(out_valid),  32'h0);
                chk("reset_busy",      32'(busy),       32'h0);
                chk("reset_in_ready",  32'(in_ready),   32'h1);

                run_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
                run_op("mixed", 32'h1234_5678, 32'h8765_4321, 1'b1, 1'b0, 32'h9999_999A, 1'b0);

                // Back-pressure: result must hold while new operands are offered.
                start_op(32'h1, 32'h2, 1'b0, 1'b0);
                wait_valid(lat);
                chk("bp_latency", 32'(lat), 32'(NN));
                A = 32'hDEAD_BEEF; B = 32'h1111_1111; Pin = 1'b1; in_valid = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_S",         S,              32'h3);
                    chk("bp_Pout",      32'(Pout),      32'h0);
                    chk("bp_in_ready",  32'(in_ready),  32'h0);
                    chk("bp_out_valid", 32'(out_valid), 32'h1);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
                release_out();
                @(negedge clk);
                chk("bp_idle_in_ready",  32'(in_ready),  32'h1);
                chk("bp_idle_out_valid", 32'(out_valid), 32'h0);
                chk("bp_idle_S_hold",    S,              32'h3);

                // Abort in the fourth compute cycle.
                start_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 1'b0);
                repeat (3) @(posedge clk);
                #1 rst = 1'b1;
                @(negedge clk);
                chk("abort_S",         S,              32'h0);
                chk("abort_Pout",      32'(Pout),      32'h0);
                chk("abort_out_valid", 32'(out_valid), 32'h0);
                chk("abort_in_ready",  32'(in_ready),  32'h1);
                @(posedge clk); #1 rst = 1'b0;
                run_op("post_abort", 32'h3, 32'h4, 1'b0, 1'b0, 32'h7, 1'b0);

                // Streaming: consumer always ready, producer always valid.
                out_ready = 1'b1;
                A = tp_a[0]; B = tp_b[0]; Pin = tp_c[0]; sub = 1'b0;
                in_valid = 1'b1;
                n_acc = 0; n_res = 0; cyc = 0;
                while (n_res < 4 && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                    if (out_valid) begin
                        chk("stream_S",    S,         tp_s[n_res]);
                        chk("stream_Pout", 32'(Pout), 32'(tp_p[n_res]));
                        n_res++;
                    end
                    if (in_valid && in_ready) begin
                        acc_cyc[n_acc] = cyc;
                        n_acc++;
                        @(posedge clk); #1;
                        if (n_acc < 4) begin
                            A = tp_a[n_acc]; B = tp_b[n_acc]; Pin = tp_c[n_acc];
                        end else begin
                            in_valid = 1'b0;
                        end
                    end
                end
                chk("stream_results", 32'(n_res), 32'd4);
                chk("stream_accepts", 32'(n_acc), 32'd4);
                for (int i = 0; i < 3; i++) begin
                    if (i + 1 < n_acc)
                        chk("stream_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'(NN + 2));
                end
                out_ready = 1'b0;
                in_valid  = 1'b0;
                @(posedge clk); #1;

`ifdef FULLADDER32_SUB_EN
                run_op("sub_borrow", 32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
                run_op("sub_noborrow", 32'h7, 32'h5, 1'b0, 1'b1, 32'h0000_0002, 1'b1);
                run_op("sub_off", 32'h7, 32'h5, 1'b0, 1'b0, 32'h0000_000C, 1'b0);
`endif

                repeat (2) @(posedge clk);
                @(negedge clk);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        join
    end
endmodule

`default_nettype wire
